// File: rtl/alu_rsv_station_pkg.sv
// Shared types for the ALU reservation station: dispatch packet, CDB broadcast, RS entry.
package alu_rsv_station_pkg;

   localparam int unsigned PREG_W   = 6;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned ALU_OP_W = 4;

   typedef struct packed {
      logic [PREG_W-1:0]   rs1_phys;
      logic [PREG_W-1:0]   rs2_phys;
      logic [PREG_W-1:0]   rd_phys;
      logic [ALU_OP_W-1:0] alu_op;
      logic [XLEN-1:0]     imm;
   } dispatch_packet_t;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] tag;
      logic [XLEN-1:0]   data;
   } cdb_t;

   typedef struct packed {
      logic             valid;
      logic             rdy1;
      logic             rdy2;
      dispatch_packet_t pkt;
   } rs_entry_t;

   // True when the CDB is broadcasting the given physical register this cycle.
   function automatic logic tag_hit(input cdb_t c, input logic [PREG_W-1:0] t);
      return c.valid && (c.tag == t);
   endfunction

endpackage

// File: rtl/alu_rsv_station_if.sv
// Dispatch, CDB snoop and issue bundle of the ALU reservation station.
interface alu_rsv_station_if #(parameter int unsigned DEPTH = 8);
   import alu_rsv_station_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             flush_i;
   logic             disp_valid_i;
   logic             disp_ready_o;
   dispatch_packet_t disp_pkt_i;
   logic             disp_rs1_rdy_i;
   logic             disp_rs2_rdy_i;
   cdb_t             cdb_i;
   logic             issue_valid_o;
   logic             issue_ready_i;
   dispatch_packet_t issue_pkt_o;
   logic [CNT_W-1:0] count_o;

   modport master (
      output flush_i, disp_valid_i, disp_pkt_i, disp_rs1_rdy_i, disp_rs2_rdy_i,
             cdb_i, issue_ready_i,
      input  disp_ready_o, issue_valid_o, issue_pkt_o, count_o
   );

   modport slave (
      input  flush_i, disp_valid_i, disp_pkt_i, disp_rs1_rdy_i, disp_rs2_rdy_i,
             cdb_i, issue_ready_i,
      output disp_ready_o, issue_valid_o, issue_pkt_o, count_o
   );

endinterface

// File: rtl/alu_rsv_station_age_select.sv
// Age matrix and oldest-eligible pick for the reservation station.
// older_q[i][j]=1 means entry j was allocated before entry i.
module rs_age_select #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [DEPTH-1:0]         eligible,
   input  logic [DEPTH-1:0]         valid,
   input  logic                     alloc_en,
   input  logic [$clog2(DEPTH)-1:0] alloc_idx,
   output logic [DEPTH-1:0]         grant,
   output logic [$clog2(DEPTH)-1:0] grant_idx
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0] older_q [DEPTH];

   // New entry is younger than every surviving entry; stale column bits for it are cleared.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      end else if (alloc_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) == alloc_idx) older_q[i] <= valid;
            else                        older_q[i][alloc_idx] <= 1'b0;
         end
      end
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = eligible[i] && !(|(older_q[i] & eligible));
         if (grant[i]) grant_idx = IDX_W'(i);
      end
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      (|eligible) |-> $onehot(grant));

endmodule

// File: rtl/alu_rsv_station.sv
// ALU reservation station: holds renamed ops by tag, wakes sources off the CDB,
// issues the oldest op whose sources are both ready.
module alu_rsv_station
   import alu_rsv_station_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input logic              clk,
   input logic              rst,
   alu_rsv_station_if.slave rs
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   rs_entry_t        ent_q [DEPTH];
   rs_entry_t        ent_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [DEPTH-1:0] valid_vec, eligible, grant, keep_vec;
   logic [IDX_W-1:0] grant_idx, alloc_idx;
   logic             accept, fire;
   logic             unused_cdb_data;

   assign unused_cdb_data = ^rs.cdb_i.data;

   always_comb begin
      valid_vec = '0;
      eligible  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = ent_q[i].valid;
         eligible[i]  = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
      end
   end

   // Lowest-index free slot.
   always_comb begin
      alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_vec[i]) alloc_idx = IDX_W'(i);
      end
   end

   assign rs.disp_ready_o  = (count_q != CNT_W'(DEPTH));
   assign rs.issue_valid_o = |eligible;
   assign rs.issue_pkt_o   = ent_q[grant_idx].pkt;
   assign rs.count_o       = count_q;
   assign accept   = rs.disp_valid_i && rs.disp_ready_o && !rs.flush_i;
   assign fire     = rs.issue_valid_o && rs.issue_ready_i && !rs.flush_i;
   assign keep_vec = valid_vec & ~(fire ? grant : '0);

   rs_age_select #(.DEPTH(DEPTH)) u_age (
      .clk       (clk),
      .rst       (rst),
      .flush     (rs.flush_i),
      .eligible  (eligible),
      .valid     (keep_vec),
      .alloc_en  (accept),
      .alloc_idx (alloc_idx),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Wakeup, issue invalidation and allocation (with same-cycle CDB bypass).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].valid) begin
            ent_d[i].rdy1 = ent_q[i].rdy1 | tag_hit(rs.cdb_i, ent_q[i].pkt.rs1_phys);
            ent_d[i].rdy2 = ent_q[i].rdy2 | tag_hit(rs.cdb_i, ent_q[i].pkt.rs2_phys);
         end
         if (fire && grant[i]) ent_d[i].valid = 1'b0;
      end
      if (accept) begin
         ent_d[alloc_idx] = '{valid: 1'b1,
                              rdy1:  rs.disp_rs1_rdy_i | tag_hit(rs.cdb_i, rs.disp_pkt_i.rs1_phys),
                              rdy2:  rs.disp_rs2_rdy_i | tag_hit(rs.cdb_i, rs.disp_pkt_i.rs2_phys),
                              pkt:   rs.disp_pkt_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || rs.flush_i) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         if (accept && !fire)      count_q <= count_q + CNT_W'(1);
         else if (fire && !accept) count_q <= count_q - CNT_W'(1);
      end
   end

   a_count_popcount: assert property (@(posedge clk) disable iff (rst)
      count_q == CNT_W'($countones(valid_vec)));

endmodule

// File: tb/tb_alu_rsv_station.sv
// Randomized bench for alu_rsv_station against an age-ordered queue model.
module tb_alu_rsv_station;
   import alu_rsv_station_pkg::*;

   localparam int unsigned DEPTH = 8;

   typedef struct {
      dispatch_packet_t pkt;
      bit               r1;
      bit               r2;
   } m_ent_t;

   logic   clk;
   logic   rst;
   int     total;
   int     bad;
   m_ent_t mq[$];

   alu_rsv_station_if #(.DEPTH(DEPTH)) rs_bus ();

   alu_rsv_station #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .rs  (rs_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic dispatch_packet_t mk_pkt(input int s1, input int s2);
      dispatch_packet_t p;
      p.rs1_phys = PREG_W'(s1);
      p.rs2_phys = PREG_W'(s2);
      p.rd_phys  = PREG_W'($urandom_range(0, 63));
      p.alu_op   = ALU_OP_W'($urandom_range(0, 15));
      p.imm      = $urandom;
      return p;
   endfunction

   // One cycle: apply inputs, compare outputs with the model, advance model and clock.
   task automatic step(input bit rst_v, input bit flush_v, input bit dv, input dispatch_packet_t pkt,
                       input bit r1, input bit r2, input bit cv, input int ctag, input bit ir);
      int  pick;
      bit  exp_rdy;
      m_ent_t e;
      rst                   = rst_v;
      rs_bus.flush_i        = flush_v;
      rs_bus.disp_valid_i   = dv;
      rs_bus.disp_pkt_i     = pkt;
      rs_bus.disp_rs1_rdy_i = r1;
      rs_bus.disp_rs2_rdy_i = r2;
      rs_bus.cdb_i          = '{valid: cv, tag: PREG_W'(ctag), data: $urandom};
      rs_bus.issue_ready_i  = ir;

      pick = -1;
      foreach (mq[k]) if (pick < 0 && mq[k].r1 && mq[k].r2) pick = k;
      exp_rdy = (mq.size() != DEPTH);
      #1;
      check("count",       64'(rs_bus.count_o),       64'(mq.size()));
      check("disp_ready",  64'(rs_bus.disp_ready_o),  64'(exp_rdy));
      check("issue_valid", 64'(rs_bus.issue_valid_o), 64'(pick >= 0));
      if (pick >= 0) check("issue_pkt", 64'(rs_bus.issue_pkt_o), 64'(mq[pick].pkt));

      if (rst_v || flush_v) begin
         mq.delete();
      end else begin
         if (pick >= 0 && ir) mq.delete(pick);
         if (cv) begin
            foreach (mq[k]) begin
               if (int'(mq[k].pkt.rs1_phys) == ctag) mq[k].r1 = 1'b1;
               if (int'(mq[k].pkt.rs2_phys) == ctag) mq[k].r2 = 1'b1;
            end
         end
         if (dv && exp_rdy) begin
            e.pkt = pkt;
            e.r1  = r1 || (cv && int'(pkt.rs1_phys) == ctag);
            e.r2  = r2 || (cv && int'(pkt.rs2_phys) == ctag);
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ir);
      for (int i = 0; i < n; i++) step(0, 0, 0, mk_pkt(0, 0), 0, 0, 0, 0, ir);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      rs_bus.flush_i = 1'b0; rs_bus.disp_valid_i = 1'b0; rs_bus.issue_ready_i = 1'b0;
      rs_bus.disp_pkt_i = '0; rs_bus.disp_rs1_rdy_i = 1'b0; rs_bus.disp_rs2_rdy_i = 1'b0;
      rs_bus.cdb_i = '0;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();

      // Ready op into empty RS issues next cycle.
      step(0, 0, 1, mk_pkt(5, 6), 1, 1, 0, 0, 1);
      idle(2, 1);
      // A waits on p9, B ready; wake A via CDB.
      step(0, 0, 1, mk_pkt(9, 1), 0, 1, 0, 0, 0);
      step(0, 0, 1, mk_pkt(2, 3), 1, 1, 0, 0, 0);
      step(0, 0, 0, mk_pkt(0, 0), 0, 0, 1, 9, 1);
      idle(3, 1);
      // Same-cycle CDB bypass on dispatch.
      step(0, 0, 1, mk_pkt(4, 7), 1, 0, 1, 7, 1);
      idle(2, 1);
      // Fill, then fire while full with dispatch pending.
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, mk_pkt(i, i + 1), 1, 1, 0, 0, 0);
      step(0, 0, 1, mk_pkt(1, 1), 1, 1, 0, 0, 1);
      step(0, 0, 1, mk_pkt(1, 1), 1, 1, 0, 0, 0);
      idle(1, 0);
      // Flush with dispatch, then reset with dispatch.
      step(0, 1, 1, mk_pkt(1, 1), 1, 1, 0, 0, 1);
      idle(1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, mk_pkt(i, 2), 1, 0, 0, 0, 0);
      step(1, 0, 1, mk_pkt(1, 1), 1, 1, 1, 2, 1);
      idle(1, 1);

      // Random phases with varying back-pressure.
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 99) < 60,
                 mk_pkt($urandom_range(0, 15), $urandom_range(0, 15)),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 15),
                 $urandom_range(0, 99) < (ph * 30 + 5));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
